// File: rtl/exec_core.sv
// rtl/exec_core.sv - shift/reduce execution core with value stack and register file
module exec_core #(
  parameter int         DATA_W   = 8,
  parameter int         DEPTH    = 64,
  parameter int         NREG     = 16,
  parameter logic [7:0] NUM_BIAS = 8'h60
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     I_VALID,
  output logic                     I_READY,
  input  logic                     I_SHIFT_EN,
  input  logic [7:0]               I_TOKEN,
  input  logic [DATA_W-1:0]        I_VALUE,
  input  logic                     I_REDUCE_EN,
  input  logic [3:0]               I_RULE,
  output logic                     O_VALID,
  output logic [DATA_W-1:0]        O_RESULT,
  output logic                     O_ERR,
  output logic [1:0]               O_ERR_CODE,
  output logic [$clog2(DEPTH):0]   O_DEPTH
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(NREG);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_POP   = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam logic [1:0] E_UNDER   = 2'b01;
  localparam logic [1:0] E_OVER    = 2'b10;
  localparam logic [1:0] E_ILLEGAL = 2'b11;

  localparam logic [7:0] TOK_NUM      = 8'h02;
  localparam logic [7:0] TOK_VAR      = 8'h0b;
  localparam logic [3:0] RULE_ILLEGAL = 4'd15;

  logic [1:0]        state;
  logic [AW:0]       sp;
  logic [1:0]        cnt;
  logic [3:0]        rule_q;
  logic [DATA_W-1:0] stack   [DEPTH];
  logic [DATA_W-1:0] regs    [NREG];
  logic [DATA_W-1:0] pop_buf [0:3];

  logic              cmd_shift, cmd_reduce, cmd_both, tok_push;
  logic              sp_empty, sp_full;
  logic [AW-1:0]     top_idx, push_idx;
  logic [DATA_W-1:0] shift_data;
  logic [DATA_W-1:0] op_a, op_b, op_c;
  logic              shift_big;
  logic              push_en, reg_we, out_en;
  logic [DATA_W-1:0] push_val;
  logic              stk_we;
  logic [DATA_W-1:0] stk_wdata;
  logic              err_hit;
  logic [1:0]        err_val;

  // Number of stack entries each rule consumes; rule 15 never reaches POP.
  function automatic logic [1:0] pop_count(input logic [3:0] r);
    case (r)
      4'd0, 4'd1:                      pop_count = 2'd0;
      4'd4, 4'd6, 4'd7, 4'd9, 4'd10:   pop_count = 2'd2;
      4'd5:                            pop_count = 2'd3;
      4'd15:                           pop_count = 2'd0;
      default:                         pop_count = 2'd1;
    endcase
  endfunction

  assign cmd_shift  = I_VALID & I_SHIFT_EN & ~I_REDUCE_EN;
  assign cmd_reduce = I_VALID & I_REDUCE_EN & ~I_SHIFT_EN;
  assign cmd_both   = I_VALID & I_SHIFT_EN & I_REDUCE_EN;
  assign tok_push   = (I_TOKEN == TOK_NUM) | (I_TOKEN == TOK_VAR);
  assign shift_data = (I_TOKEN == TOK_NUM) ? I_VALUE - DATA_W'(NUM_BIAS) : I_VALUE;

  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == (AW+1)'(DEPTH));
  assign top_idx  = AW'(sp - 1'b1);
  assign push_idx = sp[AW-1:0];
  assign O_DEPTH  = sp;

  // A reduce is reported as accepted only while its EXEC cycle is running.
  assign I_READY = ~RST & (((state == ST_READY) & cmd_shift) | ((state == ST_EXEC) & cmd_reduce));

  assign op_a      = pop_buf[0];
  assign op_b      = pop_buf[1];
  assign op_c      = pop_buf[2];
  assign shift_big = (32'(op_b) >= DATA_W);

  // Decode what the buffered rule does during its EXEC cycle.
  always_comb begin
    push_en  = 1'b0;
    push_val = '0;
    reg_we   = 1'b0;
    out_en   = 1'b0;
    case (rule_q)
      4'd3:  out_en = 1'b1;
      4'd4:  reg_we = 1'b1;
      4'd5:  reg_we = (op_c != '0);
      4'd6: begin
        push_en  = 1'b1;
        push_val = shift_big ? '0 : op_a << op_b;
      end
      4'd7: begin
        push_en  = 1'b1;
        push_val = shift_big ? '0 : op_a >> op_b;
      end
      4'd8, 4'd11, 4'd12, 4'd14: begin
        push_en  = 1'b1;
        push_val = op_a;
      end
      4'd9: begin
        push_en  = 1'b1;
        push_val = op_a + op_b;
      end
      4'd10: begin
        push_en  = 1'b1;
        push_val = op_a - op_b;
      end
      4'd13: begin
        push_en  = 1'b1;
        push_val = regs[op_a[RW-1:0]];
      end
      default: ;
    endcase
  end

  // Single stack write port shared by token shifts and rule results; full stack drops the data.
  always_comb begin
    stk_we    = 1'b0;
    stk_wdata = '0;
    if (!RST) begin
      if (state == ST_READY && cmd_shift && tok_push && !sp_full) begin
        stk_we    = 1'b1;
        stk_wdata = shift_data;
      end else if (state == ST_EXEC && push_en && !sp_full) begin
        stk_we    = 1'b1;
        stk_wdata = push_val;
      end
    end
  end

  // Error detection for the current cycle; only the first one is latched.
  always_comb begin
    err_hit = 1'b0;
    err_val = 2'b00;
    case (state)
      ST_READY: begin
        if (cmd_both || (cmd_reduce && I_RULE == RULE_ILLEGAL)) begin
          err_hit = 1'b1;
          err_val = E_ILLEGAL;
        end else if (cmd_shift && tok_push && sp_full) begin
          err_hit = 1'b1;
          err_val = E_OVER;
        end
      end
      ST_POP: begin
        if (cnt != 2'd0 && sp_empty) begin
          err_hit = 1'b1;
          err_val = E_UNDER;
        end
      end
      ST_EXEC: begin
        if (push_en && sp_full) begin
          err_hit = 1'b1;
          err_val = E_OVER;
        end
      end
      default: ;
    endcase
  end

  // Stack storage; occupancy lives in sp so the array needs no reset.
  always_ff @(posedge CLK) begin
    if (stk_we) stack[push_idx] <= stk_wdata;
  end

  // Control FSM, stack pointer, register file, result and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_READY;
      sp         <= '0;
      cnt        <= '0;
      rule_q     <= '0;
      O_RESULT   <= '0;
      O_VALID    <= 1'b0;
      O_ERR      <= 1'b0;
      O_ERR_CODE <= 2'b00;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      for (int i = 0; i < 4; i++) pop_buf[i] <= '0;
    end else begin
      O_VALID <= 1'b0;
      if (err_hit && !O_ERR) begin
        O_ERR      <= 1'b1;
        O_ERR_CODE <= err_val;
      end
      case (state)
        ST_READY: begin
          if (cmd_shift) begin
            if (stk_we) sp <= sp + 1'b1;
          end else if (cmd_reduce && I_RULE != RULE_ILLEGAL) begin
            rule_q <= I_RULE;
            cnt    <= pop_count(I_RULE);
            state  <= ST_POP;
          end
        end
        ST_POP: begin
          if (cnt == 2'd0) begin
            state <= ST_EXEC;
          end else if (sp_empty) begin
            cnt   <= 2'd0;
            state <= ST_READY;
          end else begin
            // First pop is the old top, so it lands in the highest slot of the group.
            pop_buf[cnt - 1'b1] <= stack[top_idx];
            sp    <= sp - 1'b1;
            cnt   <= cnt - 1'b1;
            if (cnt == 2'd1) state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_READY;
          if (stk_we) sp <= sp + 1'b1;
          if (reg_we) regs[op_a[RW-1:0]] <= op_b;
          if (out_en) begin
            O_RESULT <= op_a;
            O_VALID  <= 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// tb/tb_exec_core.sv - self-checking bench for exec_core
module tb_exec_core;
  localparam int DW   = 8;
  localparam int DP   = 4;
  localparam int NR   = 16;
  localparam int MASK = (1 << DW) - 1;

  localparam int K_RST  = 0;
  localparam int K_SH   = 1;
  localparam int K_RED  = 2;
  localparam int K_BOTH = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              I_VALID, I_READY, I_SHIFT_EN, I_REDUCE_EN;
  logic [7:0]        I_TOKEN;
  logic [DW-1:0]     I_VALUE;
  logic [3:0]        I_RULE;
  logic              O_VALID, O_ERR;
  logic [DW-1:0]     O_RESULT;
  logic [1:0]        O_ERR_CODE;
  logic [$clog2(DP):0] O_DEPTH;

  always #5 CLK = ~CLK;

  exec_core #(.DATA_W(DW), .DEPTH(DP), .NREG(NR), .NUM_BIAS(8'h60)) dut (
    .CLK(CLK), .RST(RST), .I_VALID(I_VALID), .I_READY(I_READY),
    .I_SHIFT_EN(I_SHIFT_EN), .I_TOKEN(I_TOKEN), .I_VALUE(I_VALUE),
    .I_REDUCE_EN(I_REDUCE_EN), .I_RULE(I_RULE), .O_VALID(O_VALID),
    .O_RESULT(O_RESULT), .O_ERR(O_ERR), .O_ERR_CODE(O_ERR_CODE), .O_DEPTH(O_DEPTH)
  );

  int vtotal = 0;
  always @(negedge CLK) if (O_VALID === 1'b1) vtotal++;

  int pops_tbl[16] = '{0, 0, 1, 1, 2, 3, 2, 2, 1, 2, 2, 1, 1, 1, 1, 0};

  int npass  = 0;
  int ntotal = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    I_VALID = 1'b0; I_SHIFT_EN = 1'b0; I_REDUCE_EN = 1'b0;
    I_TOKEN = 8'h00; I_VALUE = '0; I_RULE = 4'd0;
  endtask

  task automatic run_cmd(input int kind, input logic [7:0] tok, input logic [7:0] val,
                         input logic [3:0] rule, output int rdy, output int nv);
    int v0;
    int n;
    v0 = vtotal;
    @(negedge CLK);
    case (kind)
      K_RST: begin
        RST = 1'b1; I_VALID = 1'b1; I_SHIFT_EN = 1'b1; I_TOKEN = 8'h02;
        #1 rdy = int'(I_READY);
        @(negedge CLK);
        RST = 1'b0; idle_inputs();
      end
      K_SH: begin
        I_VALID = 1'b1; I_SHIFT_EN = 1'b1; I_TOKEN = tok; I_VALUE = val;
        #1 rdy = int'(I_READY);
        @(negedge CLK);
        idle_inputs();
      end
      K_RED: begin
        I_VALID = 1'b1; I_REDUCE_EN = 1'b1; I_RULE = rule;
        #1 rdy = int'(I_READY);
        @(negedge CLK);
        idle_inputs();
        n = (pops_tbl[rule] > 1) ? pops_tbl[rule] : 1;
        repeat (n + 1) @(negedge CLK);
      end
      default: begin
        I_VALID = 1'b1; I_SHIFT_EN = 1'b1; I_REDUCE_EN = 1'b1; I_TOKEN = 8'h02;
        I_VALUE = val; I_RULE = rule;
        #1 rdy = int'(I_READY);
        @(negedge CLK);
        idle_inputs();
      end
    endcase
    @(negedge CLK);
    nv = vtotal - v0;
  endtask

  // Behavioural reference: whole-command semantics on a queue.
  int mstk[$];
  int mregs[NR];
  int mres, mcode, mv;
  bit merr;

  function automatic void mraise(input int c);
    if (!merr) begin
      merr  = 1'b1;
      mcode = c;
    end
  endfunction

  function automatic void mpush(input int x);
    if (mstk.size() >= DP) mraise(2);
    else mstk.push_back(x & MASK);
  endfunction

  function automatic void model_cmd(input int kind, input int tok, input int val, input int rule);
    int p[3];
    int n;
    mv = 0;
    case (kind)
      K_RST: begin
        mstk.delete();
        foreach (mregs[i]) mregs[i] = 0;
        mres = 0; merr = 1'b0; mcode = 0;
      end
      K_SH: begin
        if (tok == 8'h02) mpush(val - 8'h60);
        else if (tok == 8'h0b) mpush(val);
      end
      K_RED: begin
        if (rule == 15) mraise(3);
        else begin
          n = pops_tbl[rule];
          if (mstk.size() < n) begin
            mraise(1);
            mstk.delete();
          end else begin
            for (int i = n - 1; i >= 0; i--) p[i] = mstk.pop_back();
            case (rule)
              3:  begin mres = p[0]; mv = 1; end
              4:  mregs[p[0] % NR] = p[1];
              5:  if (p[2] != 0) mregs[p[0] % NR] = p[1];
              6:  mpush(p[1] >= DW ? 0 : p[0] << p[1]);
              7:  mpush(p[1] >= DW ? 0 : p[0] >> p[1]);
              9:  mpush(p[0] + p[1]);
              10: mpush(p[0] - p[1]);
              13: mpush(mregs[p[0] % NR]);
              8, 11, 12, 14: mpush(p[0]);
              default: ;
            endcase
          end
        end
      end
      default: mraise(3);
    endcase
  endfunction

  typedef struct {
    int         kind;
    logic [7:0] tok;
    logic [7:0] val;
    logic [3:0] rule;
    int         d, r, e, c, v;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input int kind, input int tok, input int val, input int rule,
                              input int d, input int r, input int e, input int c, input int v);
    vec_t x;
    x.kind = kind; x.tok = 8'(tok); x.val = 8'(val); x.rule = 4'(rule);
    x.d = d; x.r = r; x.e = e; x.c = c; x.v = v;
    tbl.push_back(x);
  endfunction

  task automatic probe_latency(input logic [3:0] rule, input int ready_at, input string nm);
    @(negedge CLK);
    I_VALID = 1'b1; I_REDUCE_EN = 1'b1; I_RULE = rule;
    @(negedge CLK);
    I_REDUCE_EN = 1'b0; I_SHIFT_EN = 1'b1; I_TOKEN = 8'h00;
    for (int k = 1; k <= ready_at; k++) begin
      #1 chk($sformatf("%s cyc%0d ready", nm, k), 32'(I_READY), 32'(k == ready_at));
      if (k < ready_at) @(negedge CLK);
    end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
  endtask

  initial begin
    int rdy, nv, kind, tok, val, rule, sel;
    idle_inputs();

    row(K_RST, 0, 0, 0,      0, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h63, 0, 1, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h64, 0, 2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 12,     2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 11,     2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 12,     2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 11,     2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 9,      1, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 8,      1, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h07, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h05, 0, 1, 8'h07, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h09, 0, 2, 8'h07, 0, 0, 0);
    row(K_RED, 0, 0, 4,      0, 8'h07, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h05, 0, 1, 8'h07, 0, 0, 0);
    row(K_RED, 0, 0, 13,     1, 8'h07, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h09, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h05, 0, 1, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h07, 0, 2, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h00, 0, 3, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 5,      0, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h05, 0, 1, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 13,     1, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h09, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h06, 0, 1, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h2a, 0, 2, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h01, 0, 3, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 5,      0, 8'h09, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h06, 0, 1, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 13,     1, 8'h09, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h2a, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h01, 0, 1, 8'h2a, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h09, 0, 2, 8'h2a, 0, 0, 0);
    row(K_RED, 0, 0, 6,      1, 8'h2a, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h00, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h03, 0, 1, 8'h00, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h05, 0, 2, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 10,     1, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'hfe, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h80, 0, 1, 8'hfe, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h03, 0, 2, 8'hfe, 0, 0, 0);
    row(K_RED, 0, 0, 7,      1, 8'hfe, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h10, 0, 0, 1);
    row(K_SH, 8'h0b, 8'h03, 0, 1, 8'h10, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h02, 0, 2, 8'h10, 0, 0, 0);
    row(K_RED, 0, 0, 6,      1, 8'h10, 0, 0, 0);
    row(K_RED, 0, 0, 3,      0, 8'h0c, 0, 0, 1);
    row(K_SH, 8'h05, 8'h77, 0, 0, 8'h0c, 0, 0, 0);
    row(K_SH, 8'h0b, 8'h11, 0, 1, 8'h0c, 0, 0, 0);
    row(K_RED, 0, 0, 0,      1, 8'h0c, 0, 0, 0);
    row(K_RED, 0, 0, 1,      1, 8'h0c, 0, 0, 0);
    row(K_RED, 0, 0, 2,      0, 8'h0c, 0, 0, 0);
    row(K_RST, 0, 0, 0,      0, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h61, 0, 1, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h62, 0, 2, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h63, 0, 3, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h64, 0, 4, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h65, 0, 4, 8'h00, 1, 2, 0);
    row(K_RED, 0, 0, 3,      3, 8'h04, 1, 2, 1);
    row(K_RED, 0, 0, 3,      2, 8'h03, 1, 2, 1);
    row(K_RED, 0, 0, 3,      1, 8'h02, 1, 2, 1);
    row(K_RED, 0, 0, 3,      0, 8'h01, 1, 2, 1);
    row(K_RED, 0, 0, 9,      0, 8'h01, 1, 2, 0);
    row(K_RST, 0, 0, 0,      0, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 9,      0, 8'h00, 1, 1, 0);
    row(K_RST, 0, 0, 0,      0, 8'h00, 0, 0, 0);
    row(K_RED, 0, 0, 15,     0, 8'h00, 1, 3, 0);
    row(K_RST, 0, 0, 0,      0, 8'h00, 0, 0, 0);
    row(K_SH, 8'h02, 8'h62, 0, 1, 8'h00, 0, 0, 0);
    row(K_BOTH, 0, 8'h62, 3, 1, 8'h00, 1, 3, 0);
    row(K_RED, 0, 0, 3,      0, 8'h02, 1, 3, 1);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].kind, tbl[i].tok, tbl[i].val, tbl[i].rule, rdy, nv);
      chk($sformatf("vec%0d depth", i), 32'(O_DEPTH), 32'(tbl[i].d));
      chk($sformatf("vec%0d result", i), 32'(O_RESULT), 32'(tbl[i].r));
      chk($sformatf("vec%0d err", i), 32'(O_ERR), 32'(tbl[i].e));
      chk($sformatf("vec%0d code", i), 32'(O_ERR_CODE), 32'(tbl[i].c));
      chk($sformatf("vec%0d valid_pulses", i), 32'(nv), 32'(tbl[i].v));
      chk($sformatf("vec%0d i_ready", i), 32'(rdy), 32'(tbl[i].kind == K_SH));
    end

    // Reduce latency: pop count + 2 cycles, zero-pop rules spend one POP cycle.
    run_cmd(K_RST, 0, 0, 0, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h01, 0, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h02, 0, rdy, nv);
    probe_latency(4'd9, 4, "lat_rule9");
    chk("lat_rule9 depth", 32'(O_DEPTH), 32'd1);
    probe_latency(4'd0, 3, "lat_rule0");
    chk("lat_rule0 depth", 32'(O_DEPTH), 32'd1);
    run_cmd(K_RST, 0, 0, 0, rdy, nv);
    probe_latency(4'd9, 2, "lat_underflow");
    chk("lat_underflow code", 32'(O_ERR_CODE), 32'd1);
    chk("lat_underflow depth", 32'(O_DEPTH), 32'd0);

    // Reset in the middle of a rule discards it and clears the register file.
    run_cmd(K_RST, 0, 0, 0, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h05, 0, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h09, 0, rdy, nv);
    run_cmd(K_RED, 0, 0, 4'd4, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h05, 0, rdy, nv);
    run_cmd(K_SH, 8'h0b, 8'h33, 0, rdy, nv);
    @(negedge CLK);
    I_VALID = 1'b1; I_REDUCE_EN = 1'b1; I_RULE = 4'd4;
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midpop_rst depth", 32'(O_DEPTH), 32'd0);
    chk("midpop_rst err", 32'(O_ERR), 32'd0);
    chk("midpop_rst valid", 32'(O_VALID), 32'd0);
    I_VALID = 1'b1; I_SHIFT_EN = 1'b1; I_TOKEN = 8'h00;
    #1 chk("midpop_rst ready_state", 32'(I_READY), 32'd1);
    @(negedge CLK);
    idle_inputs();
    run_cmd(K_SH, 8'h0b, 8'h05, 0, rdy, nv);
    run_cmd(K_RED, 0, 0, 4'd13, rdy, nv);
    run_cmd(K_RED, 0, 0, 4'd3, rdy, nv);
    chk("midpop_rst reg5", 32'(O_RESULT), 32'd0);
    chk("midpop_rst reg5 pulse", 32'(nv), 32'd1);

    // Randomized commands against the queue model.
    run_cmd(K_RST, 0, 0, 0, rdy, nv);
    model_cmd(K_RST, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 99));
      tok = 0; val = 0; rule = 0;
      if (sel < 3) kind = K_RST;
      else if (sel < 5) kind = K_BOTH;
      else if (sel < 50) kind = K_SH;
      else kind = K_RED;
      val = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 11));
      case ($urandom_range(0, 2))
        0: tok = 8'h02;
        1: tok = 8'h0b;
        default: begin
          tok = int'($urandom_range(0, 255));
          if (tok == 8'h02 || tok == 8'h0b) tok = 8'h20;
        end
      endcase
      rule = ($urandom_range(0, 29) == 0) ? 15 : int'($urandom_range(0, 14));
      run_cmd(kind, 8'(tok), 8'(val), 4'(rule), rdy, nv);
      model_cmd(kind, tok, val, rule);
      chk($sformatf("rnd%0d depth", i), 32'(O_DEPTH), 32'(mstk.size()));
      chk($sformatf("rnd%0d err", i), 32'(O_ERR), 32'(merr));
      chk($sformatf("rnd%0d code", i), 32'(O_ERR_CODE), 32'(mcode));
      chk($sformatf("rnd%0d result", i), 32'(O_RESULT), 32'(mres));
      chk($sformatf("rnd%0d valid_pulses", i), 32'(nv), 32'(mv));
      chk($sformatf("rnd%0d i_ready", i), 32'(rdy), 32'(kind == K_SH));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/exec_core.md
EXEC_CORE -- requirements
Module: exec_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of stack entries, registers and result; legal values 8..32.
REQ-002 SHALL have parameter DEPTH, default 64: value-stack entries; power of two, 4..1024.
REQ-003 SHALL have parameter NREG, default 16: register-file entries; power of two, 2..256.
REQ-004 SHALL have parameter NUM_BIAS, default 8'h60: constant subtracted from num-token values on shift.
REQ-005 SHALL have ports:
  CLK  in  1  clock; the block uses one clock.
  RST  in  1  reset; synchronous and active-high.
  I_VALID  in  1  input command present.
  I_READY  out  1  command accepted this cycle.
  I_SHIFT_EN  in  1  command is a shift.
  I_TOKEN  in  8  shift token kind.
  I_VALUE  in  DATA_W  shift token value.
  I_REDUCE_EN  in  1  command is a reduce.
  I_RULE  in  4  reduce rule id.
  O_VALID  out  1  one-cycle pulse: O_RESULT updated.
  O_RESULT  out  DATA_W  last out-statement value.
  O_ERR  out  1  sticky error flag.
  O_ERR_CODE  out  2  first error: 01 underflow, 10 overflow, 11 illegal.
  O_DEPTH  out  clog2(DEPTH)+1  current stack occupancy.

Function
REQ-006 SHALL use three states: READY, POP and EXEC; every state other than these SHALL go to READY.
REQ-007 SHALL drive I_READY = I_VALID & ((state==READY & I_SHIFT_EN & ~I_REDUCE_EN) | (state==EXEC & I_REDUCE_EN & ~I_SHIFT_EN)).
REQ-008 Shift: in READY, on I_VALID & I_SHIFT_EN, the block SHALL push in the same clock edge:
  - token 8'h02 pushes I_VALUE-NUM_BIAS, modulo 2^DATA_W;
  - token 8'h0b pushes I_VALUE;
  - any other token is accepted with no push.
REQ-009 Reduce start: in READY, on I_VALID & I_REDUCE_EN & ~I_SHIFT_EN, the block SHALL load the pop count and enter POP.
REQ-010 Pop-count table, rules 0..14: 0,0,1,1,2,3,2,2,1,2,2,1,1,1,1.
REQ-011 Rule 15 SHALL be illegal: it raises code 11 and returns to READY with no stack change.
REQ-012 POP SHALL pop one entry per cycle while the remaining count is above 0, and enter EXEC when the count reaches 0.
  - A zero-pop rule spends 1 cycle in POP.
  - popped[0] is the deepest entry of the group and popped[n-1] is the old top.
REQ-013 EXEC SHALL last exactly 1 cycle, then go to READY; reduce latency = pop count + 2 cycles from acceptance to READY.
REQ-014 Rule 3 SHALL set O_RESULT = popped[0] and pulse O_VALID high for 1 cycle.
REQ-015 Rule 4 SHALL write reg[popped[0] mod NREG] = popped[1].
REQ-016 Rule 5 SHALL do the same write as rule 4 only when popped[2] != 0.
REQ-017 Rules 6 and 7 SHALL push popped[0] shifted left or right (logical) by popped[1]; the result is 0 when popped[1] >= DATA_W.
REQ-018 Rules 9 and 10 SHALL push popped[0] + popped[1] and popped[0] - popped[1], modulo 2^DATA_W.
REQ-019 Rules 8, 11, 12 and 14 SHALL push popped[0].
REQ-020 Rule 13 SHALL push reg[popped[0] mod NREG].
REQ-021 Rules 0, 1 and 2 SHALL make no push and no register write.
REQ-022 The result push SHALL occur on the EXEC clock edge and be visible in O_DEPTH the next cycle.
REQ-023 Underflow: a pop with O_DEPTH==0 SHALL raise code 01, abort the rule (no push, no write, no O_VALID) and return to READY on the next cycle.
REQ-024 Overflow: a push with O_DEPTH==DEPTH SHALL raise code 10, drop the data and leave the stack unchanged.
REQ-025 I_VALID with both I_SHIFT_EN and I_REDUCE_EN high in READY SHALL raise code 11, return I_READY=0 and leave the state unchanged.
REQ-026 O_ERR SHALL stay set once raised; O_ERR_CODE SHALL hold the first error; later errors SHALL not change it.
REQ-027 Commands SHALL continue to run after an error.
REQ-028 O_DEPTH SHALL wrap neither above DEPTH nor below 0.

Reset
REQ-029 On RST the block SHALL clear: state = READY, stack empty (O_DEPTH=0), all NREG registers = 0, O_RESULT=0, O_VALID=0, O_ERR=0, O_ERR_CODE=00, pop count = 0.
REQ-030 RST SHALL override any state, including mid-POP and EXEC; a partly executed rule SHALL be discarded with no register write.
REQ-031 With RST high, I_READY SHALL be 0.

Verification
REQ-032 Shift tok 02 val 8'h63, shift tok 02 val 8'h64, reduce 12, 11, 12, 11, 9, 8, 3 -> O_VALID pulse with O_RESULT=7; O_DEPTH=0 at end.
REQ-033 Reduce 4 with stack [var 5, value 9], then shift var 5 and reduce 13 -> pushed value 9; reduce 5 with condition 0 -> reg 5 unchanged.
REQ-034 DATA_W=8: reduce 6 with popped [1, 9] -> pushes 0; reduce 10 with popped [3, 5] -> pushes 8'hFE.
REQ-035 DEPTH=4: five num shifts -> fifth dropped, O_ERR=1, code 10, O_DEPTH=4; a later reduce 9 on an empty stack keeps code 10.
REQ-036 From reset, reduce 9 -> code 01, no push, READY after 2 cycles; rule 15 after a fresh reset -> code 11.
REQ-037 Assert RST during the POP of reduce 4 -> next cycle: READY, O_DEPTH=0, registers all 0, O_ERR=0.
